// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared encodings and helpers for the CPU run-control sequencer.
// Mode codes come from the board switches; state codes are shown on the LEDs.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_STEP = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_STEP   = 3'd1,
    ST_SLOW   = 3'd2,
    ST_FAST   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // ceil(log2(n)), never less than 1 so a counter always has at least one bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic state_e mode_to_state(input mode_e m);
    state_e s;
    case (m)
      MODE_STEP: s = ST_STEP;
      MODE_SLOW: s = ST_SLOW;
      MODE_FAST: s = ST_FAST;
      default:   s = ST_STOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_clock_controller_debouncer.sv
// Step push-button conditioning: two-flop synchronizer, stability counter,
// and a registered one-cycle pulse on each accepted rising level.
module button_debouncer
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync_d       = {sync_q[0], btn_raw};
    level_d      = level_q;
    cnt_d        = '0;
    // Any return to the held level restarts the stability window.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync_q[1];
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
    level_prev_d = level_q;
    rise_d       = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      rise_q       <= rise_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/cpu_clock_controller.sv
// Run-control sequencer gating the MIPS core with a one-cycle clock enable.
//   state  | meaning
//   STOP   | CPU idle, no enables
//   STEP   | one enable per debounced button press
//   SLOW   | one enable every SLOW_DIV cycles
//   FAST   | enable every cycle
//   HALTED | CPU reported halt; held until resume
module cpu_clock_controller
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int SLOW_DIV        = 20_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  input  logic        cpu_halt,
  input  logic        resume,
  output logic        cpu_en,
  output logic [2:0]  state_out,
  output logic [31:0] cycle_count
);

  localparam int SLOW_W = clog2(SLOW_DIV + 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

  state_e             state_q, state_d;
  logic [SLOW_W-1:0]  slow_cnt_q, slow_cnt_d;
  logic               tick_q, tick_d;
  logic               halt_latch_q, halt_latch_d;
  logic               cpu_halt_dly_q, cpu_halt_dly_d;
  logic               cpu_en_q, cpu_en_d;
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic               halt_set;
  logic               step_req;
  logic               step_level_unused;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (step_btn),
    .btn_level(step_level_unused),
    .btn_rise (step_req)
  );

  always_comb begin
    halt_set       = cpu_halt & ~cpu_halt_dly_q;
    cpu_halt_dly_d = cpu_halt;
    // A new halt edge beats a simultaneous resume.
    halt_latch_d   = halt_set | (halt_latch_q & ~resume);
    state_d        = halt_latch_d ? ST_HALTED : mode_to_state(mode_e'(mode));

    slow_cnt_d = '0;
    tick_d     = 1'b0;
    if (state_q == ST_SLOW) begin
      if (slow_cnt_q == SLOW_LAST) tick_d     = 1'b1;
      else                         slow_cnt_d = slow_cnt_q + SLOW_W'(1);
    end

    // Suppressing on the halt edge itself keeps any instruction from
    // slipping through after the CPU reports halt.
    cpu_en_d = ~halt_set & ((state_q == ST_FAST) |
                            ((state_q == ST_SLOW) & tick_q) |
                            ((state_q == ST_STEP) & step_req));

    cycle_count_d = cycle_count_q + {31'd0, cpu_en_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_STOP;
      slow_cnt_q     <= '0;
      tick_q         <= 1'b0;
      halt_latch_q   <= 1'b0;
      cpu_halt_dly_q <= 1'b0;
      cpu_en_q       <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      slow_cnt_q     <= slow_cnt_d;
      tick_q         <= tick_d;
      halt_latch_q   <= halt_latch_d;
      cpu_halt_dly_q <= cpu_halt_dly_d;
      cpu_en_q       <= cpu_en_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign state_out   = state_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller: directed scenarios then random stimulus,
// each cycle compared against a behavioural model of the run-control rules.
module tb_cpu_clock_controller;

  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        step_btn = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        resume = 1'b0;
  logic        cpu_en;
  logic [2:0]  state_out;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          hist[$];     // button value captured at each clock edge
  int          req_at[$];   // edge indices at which a step request is active
  bit          m_held;
  int          m_run;
  int          m_st;
  bit          m_en;
  logic [31:0] m_count;
  bit          m_latch;
  bit          m_prev_halt;
  int          m_age;       // edges spent in SLOW since entering it

  cpu_clock_controller #(
    .SLOW_DIV       (SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .step_btn   (step_btn),
    .cpu_halt   (cpu_halt),
    .resume     (resume),
    .cpu_en     (cpu_en),
    .state_out  (state_out),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  t;
    bit  s, req, halt_edge, new_latch, en_next;
    int  nstate;
    if (reset) begin
      hist.push_back(1'b0);
      t = hist.size() - 1;
      if (t >= 1) hist[t-1] = 1'b0;
      req_at.delete();
      m_held = 0; m_run = 0; m_st = 0; m_en = 0; m_count = '0;
      m_latch = 0; m_prev_halt = 0; m_age = 0;
      return;
    end
    hist.push_back(step_btn);
    t = hist.size() - 1;
    s = (t >= 2) ? hist[t-2] : 1'b0;
    req = 0;
    while (req_at.size() > 0 && req_at[0] < t) void'(req_at.pop_front());
    if (req_at.size() > 0 && req_at[0] == t) begin
      req = 1;
      void'(req_at.pop_front());
    end
    // a new level is accepted after DB consecutive differing samples
    if (s != m_held) begin
      m_run++;
      if (m_run == DB) begin
        m_held = s;
        m_run  = 0;
        if (s) req_at.push_back(t + 2);
      end
    end else m_run = 0;

    halt_edge = cpu_halt && !m_prev_halt;
    new_latch = halt_edge || (m_latch && !resume);
    en_next   = !halt_edge && ((m_st == 3) ||
                               (m_st == 2 && m_age > 0 && (m_age % SD) == 0) ||
                               (m_st == 1 && req));
    m_count   = m_count + (m_en ? 32'd1 : 32'd0);
    nstate    = new_latch ? 4 : int'(mode);
    m_age     = (nstate == 2 && m_st == 2) ? m_age + 1 : 0;
    m_st      = nstate;
    m_en      = en_next;
    m_latch   = new_latch;
    m_prev_halt = cpu_halt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("cpu_en", 32'(cpu_en), 32'(m_en));
    chk("state_out", 32'(state_out), 32'(m_st));
    chk("cycle_count", cycle_count, m_count);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_count(input int n, inout int pulses);
    repeat (n) begin
      cycle();
      if (cpu_en) pulses++;
    end
  endtask

  initial begin
    int pulses, first_state, last_pulse, first_pulse, lat;
    logic [31:0] frozen;

    // reset
    reset = 1'b1; mode = 2'b00;
    run(2);
    chk("rst_en", 32'(cpu_en), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_count", cycle_count, 32'd0);

    // FAST
    reset = 1'b0; mode = 2'b11;
    run(20);
    chk("fast_count", cycle_count, 32'd18);

    // SLOW
    mode = 2'b10;
    pulses = 0; first_state = -1; last_pulse = -1; first_pulse = -1;
    for (int i = 1; i <= 21; i++) begin
      cycle();
      if (state_out == 3'd2 && first_state < 0) first_state = i;
      if (cpu_en && first_state >= 0 && i > first_state) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        if (last_pulse >= 0) chk("slow_period", 32'(i - last_pulse), 32'(SD));
        last_pulse = i;
      end
    end
    chk("slow_first", 32'(first_pulse - first_state), 32'(SD + 1));
    chk("slow_pulses", 32'(pulses), 32'd4);
    mode = 2'b00;
    run(2);
    frozen = cycle_count;
    run(6);
    chk("stop_frozen", cycle_count, frozen);

    // STEP with bounce
    mode = 2'b01;
    run(3);
    pulses = 0;
    step_btn = 1'b1; run_count(1, pulses);
    step_btn = 1'b0; run_count(1, pulses);
    step_btn = 1'b1; run_count(10, pulses);
    step_btn = 1'b0; run_count(8, pulses);
    chk("step_bounce_pulses", 32'(pulses), 32'd1);
    step_btn = 1'b1; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (cpu_en && lat == 0) lat = i;
    end
    chk("step_latency", 32'(lat), 32'(2 + DB + 2));
    step_btn = 1'b0; run(8);
    mode = 2'b00; pulses = 0;
    step_btn = 1'b1; run_count(10, pulses);
    mode = 2'b01;    run_count(10, pulses);
    chk("step_discard", 32'(pulses), 32'd0);
    step_btn = 1'b0; run(8);

    // halt and resume
    mode = 2'b11; run(4);
    cpu_halt = 1'b1; cycle();
    chk("halt_en", 32'(cpu_en), 32'd0);
    chk("halt_state", 32'(state_out), 32'd4);
    run(5);
    resume = 1'b1; cycle(); resume = 1'b0;
    chk("resume_state", 32'(state_out), 32'd3);
    run(5);
    chk("no_rehalt", 32'(cpu_en), 32'd1);
    cpu_halt = 1'b0; run(2);
    cpu_halt = 1'b1; cycle();
    chk("rehalt_state", 32'(state_out), 32'd4);

    // halt edge and resume together
    cpu_halt = 1'b0; cycle();
    cpu_halt = 1'b1; resume = 1'b1; cycle(); resume = 1'b0;
    chk("set_wins", 32'(state_out), 32'd4);
    run(3);
    chk("set_wins_hold", 32'(state_out), 32'd4);
    resume = 1'b1; cycle(); resume = 1'b0;
    run(2);

    // reset in the middle of SLOW and of a debounce window
    cpu_halt = 1'b0; mode = 2'b10; run(7);
    step_btn = 1'b1; run(3);
    reset = 1'b1; cycle();
    chk("midrst_en", 32'(cpu_en), 32'd0);
    chk("midrst_state", 32'(state_out), 32'd0);
    chk("midrst_count", cycle_count, 32'd0);
    reset = 1'b0; run(12);
    step_btn = 1'b0; run(6);

    // counter wrap
    mode = 2'b11; run(4);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count_q;
    m_count = 32'hFFFF_FFFF;
    cycle();
    chk("wrap", cycle_count, 32'd0);
    run(2);

    // random
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0)  step_btn = ~step_btn;
      if ($urandom_range(19) == 0) cpu_halt = ~cpu_halt;
      resume = ($urandom_range(24) == 0);
      reset  = ($urandom_range(199) == 0);
      cycle();
    end
    reset = 1'b0; resume = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
